// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell walks WIDTH-bit operands LSB first.
// Optional macro SERIAL_ADD_CTRL_SUB_EN adds a 'sub' port for a - b via two's complement.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co;
   logic             accept, last, sub_i;

`ifdef SERIAL_ADD_CTRL_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // DONE accepts a new start exactly like IDLE so back-to-back ops have no bubble.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= sub_i ? ~b : b;
         carry <= sub_i ? 1'b1 : cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         // Sum bits enter at the top; after WIDTH-1 shifts sum_sr holds bits WIDTH-2..0.
         sum_sr <= (sum_sr >> 1) | ((WIDTH-1)'(fa_s) << (WIDTH - 2));
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         carry  <= fa_co;
         cnt    <= cnt + CW'(1);
         if (last) begin
            sum  <= {fa_s, sum_sr};
            cout <= fa_co;
         end
      end
   end
endmodule
